// File: rtl/spi_crc_pkg.sv
// Shared constants, CRC parameters and FSM encoding for the CRC-protected SPI master.
package spi_crc_pkg;

    localparam logic [7:0] CRC_POLY = 8'h1D;
    localparam logic [7:0] CRC_INIT = 8'hFF;
    localparam int         DATA_W   = 24;
    localparam int         CRC_W    = 8;
    localparam int         FRAME_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_HI = 3'd2,
        ST_SCK_LO = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } spi_state_e;

endpackage

// File: rtl/crc8_calc.sv
// Combinational CRC8 (poly 0x1D, init 0xFF, no reflection, no final XOR) over a 24-bit word, MSB first.
module crc8_calc
    import spi_crc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);

    logic [CRC_W-1:0] acc;

    always_comb begin
        acc = CRC_INIT;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (acc[CRC_W-1] ^ data[i]) begin
                acc = {acc[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc = {acc[CRC_W-2:0], 1'b0};
            end
        end
        crc = acc;
    end

endmodule

// File: rtl/spi_master_crc.sv
// SPI master sending a 24-bit payload plus CRC8 as one 32-bit frame, checking the CRC of the received frame.
module spi_master_crc
    import spi_crc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_crc_ok,
    output logic              sck,
    output logic              csn,
    output logic              mosi,
    input  logic              miso,
    output spi_state_e        dbg_state
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    spi_state_e         state, state_nx;
    logic [7:0]         div_cnt;
    logic [5:0]         bit_cnt;
    logic [FRAME_W-1:0] tx_sr, rx_sr;
    logic [CRC_W-1:0]   tx_crc, rx_crc;
    logic               timer_done, last_bit;

    assign timer_done = (div_cnt == DIV_LAST);
    assign last_bit   = (bit_cnt == 6'd31);
    assign dbg_state  = state;

    crc8_calc u_crc_tx (.data(tx_data),                   .crc(tx_crc));
    crc8_calc u_crc_rx (.data(rx_sr[FRAME_W-1:CRC_W]),    .crc(rx_crc));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // The 32nd high phase skips SCK_LO: HOLD itself is the final low half-period.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start)      state_nx = ST_SETUP;
            ST_SETUP:  if (timer_done) state_nx = ST_SCK_HI;
            ST_SCK_HI: if (timer_done) state_nx = last_bit ? ST_HOLD : ST_SCK_LO;
            ST_SCK_LO: if (timer_done) state_nx = ST_SCK_HI;
            ST_HOLD:   if (timer_done) state_nx = ST_GAP;
            ST_GAP:    if (timer_done) state_nx = ST_IDLE;
            default:                   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b1;
        csn  = 1'b0;
        sck  = 1'b0;
        mosi = tx_sr[FRAME_W-1];
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                csn  = 1'b1;
                mosi = 1'b0;
            end
            ST_GAP: begin
                csn  = 1'b1;
                mosi = 1'b0;
            end
            ST_SCK_HI: sck = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            done      <= 1'b0;
            rx_data   <= '0;
            rx_crc_ok <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE || state_nx != state) div_cnt <= '0;
            else                                       div_cnt <= div_cnt + 8'd1;

            if (state == ST_IDLE && start) begin
                tx_sr   <= {tx_data, tx_crc};
                rx_sr   <= '0;
                bit_cnt <= '0;
            end
            // Next bit goes out as sck rises; miso is captured as sck falls.
            if (state == ST_SCK_LO && timer_done) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            if (state == ST_SCK_HI && timer_done) begin
                rx_sr   <= {rx_sr[FRAME_W-2:0], miso};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (state == ST_HOLD && timer_done) begin
                done      <= 1'b1;
                rx_data   <= rx_sr[FRAME_W-1:CRC_W];
                rx_crc_ok <= (rx_crc == rx_sr[CRC_W-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_spi_master_crc.sv
// Directed bench for spi_master_crc: frame timing, frame contents, loopback CRC check, reset abort, back-to-back.
module tb_spi_master_crc;
    import spi_crc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] tx_data = '0;
    logic        busy, done, rx_crc_ok, sck, csn, mosi, miso;
    logic [23:0] rx_data;
    spi_state_e  dbg_state;
    logic        loopback = 1'b0;
    logic        flip = 1'b0;

    logic        start1 = 1'b0;
    logic [23:0] tx_data1 = '0;
    logic        busy1, done1, rx_crc_ok1, sck1, csn1, mosi1, miso1;
    logic [23:0] rx_data1;
    spi_state_e  dbg_state1;

    int errors = 0;
    int checks = 0;

    int          o_csn_fall, o_first_rise, o_last_fall, o_csn_rise;
    int          o_done_cyc, o_busy_low, o_nrise, o_done_cnt;
    logic [31:0] o_mosi;

    assign miso  = loopback ? (mosi ^ flip) : 1'b0;
    assign miso1 = mosi1;

    always #5 clk = ~clk;

    spi_master_crc #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .rx_crc_ok(rx_crc_ok),
        .sck(sck), .csn(csn), .mosi(mosi), .miso(miso), .dbg_state(dbg_state)
    );

    spi_master_crc #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data1),
        .busy(busy1), .done(done1), .rx_data(rx_data1), .rx_crc_ok(rx_crc_ok1),
        .sck(sck1), .csn(csn1), .mosi(mosi1), .miso(miso1), .dbg_state(dbg_state1)
    );

    // Monitor one frame on dut; cycle n is sampled 1 time unit after the n-th edge following start.
    task automatic run_frame(input logic [23:0] data, input logic lb, input int flip_at);
        int   n;
        logic prev_sck;
        o_csn_fall = -1; o_first_rise = -1; o_last_fall = -1; o_csn_rise = -1;
        o_done_cyc = -1; o_busy_low = -1; o_nrise = 0; o_done_cnt = 0; o_mosi = '0;
        @(negedge clk);
        tx_data = data; loopback = lb; flip = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; tx_data = ~data;
        n = 1; prev_sck = 1'b0;
        while (n <= 400 && o_busy_low < 0) begin
            if (!csn && o_csn_fall < 0) o_csn_fall = n;
            if (sck && !prev_sck) begin
                if (o_first_rise < 0) o_first_rise = n;
                o_mosi = {o_mosi[30:0], mosi};
                o_nrise++;
            end
            if (!sck && prev_sck) o_last_fall = n;
            if (done) begin o_done_cnt++; o_done_cyc = n; end
            if (csn && o_csn_fall >= 0 && o_csn_rise < 0) o_csn_rise = n;
            if (!busy) o_busy_low = n;
            if (flip_at > 0 && n == flip_at) flip = 1'b1;
            if (flip_at > 0 && n == flip_at + 2) flip = 1'b0;
            prev_sck = sck;
            if (o_busy_low < 0) begin @(posedge clk); #1; n++; end
        end
        flip = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 8;
        if (csn !== 1'b1)         begin errors++; $display("FAIL reset_csn: got %b want 1", csn); end
        if (sck !== 1'b0)         begin errors++; $display("FAIL reset_sck: got %b want 0", sck); end
        if (mosi !== 1'b0)        begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (rx_data !== 24'h0)    begin errors++; $display("FAIL reset_rx_data: got %h want 000000", rx_data); end
        if (rx_crc_ok !== 1'b0)   begin errors++; $display("FAIL reset_crc_ok: got %b want 0", rx_crc_ok); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timing();
        run_frame(24'h000000, 1'b0, 0);
        checks += 10;
        if (o_csn_fall !== 1)     begin errors++; $display("FAIL t_csn_fall: got %0d want 1", o_csn_fall); end
        if (o_first_rise !== 3)   begin errors++; $display("FAIL t_first_rise: got %0d want 3", o_first_rise); end
        if (o_last_fall !== 129)  begin errors++; $display("FAIL t_last_fall: got %0d want 129", o_last_fall); end
        if (o_csn_rise !== 131)   begin errors++; $display("FAIL t_csn_rise: got %0d want 131", o_csn_rise); end
        if (o_done_cyc !== 131)   begin errors++; $display("FAIL t_done: got %0d want 131", o_done_cyc); end
        if (o_busy_low !== 133)   begin errors++; $display("FAIL t_busy_low: got %0d want 133", o_busy_low); end
        if (o_nrise !== 32)       begin errors++; $display("FAIL t_sck_pulses: got %0d want 32", o_nrise); end
        if (o_done_cnt !== 1)     begin errors++; $display("FAIL t_done_count: got %0d want 1", o_done_cnt); end
        if (rx_data !== 24'h0)    begin errors++; $display("FAIL t_rx_zero: got %h want 000000", rx_data); end
        if (rx_crc_ok !== 1'b0)   begin errors++; $display("FAIL t_rx_crc_zero: got %b want 0", rx_crc_ok); end
    endtask

    task automatic test_frame_contents();
        run_frame(24'h000000, 1'b0, 0);
        checks++;
        if (o_mosi !== 32'h0000000E) begin errors++; $display("FAIL frame_zero: got %h want 0000000e", o_mosi); end
        run_frame(24'hFFFFFF, 1'b0, 0);
        checks++;
        if (o_mosi !== 32'hFFFFFF85) begin errors++; $display("FAIL frame_ones: got %h want ffffff85", o_mosi); end
    endtask

    task automatic test_loopback();
        run_frame(24'hFEDCBA, 1'b1, 0);
        checks += 3;
        if (rx_data !== 24'hFEDCBA)       begin errors++; $display("FAIL lb_rx_data: got %h want fedcba", rx_data); end
        if (rx_crc_ok !== 1'b1)           begin errors++; $display("FAIL lb_crc_ok: got %b want 1", rx_crc_ok); end
        if (o_mosi[31:8] !== 24'hFEDCBA)  begin errors++; $display("FAIL lb_tx_held: got %h want fedcba", o_mosi[31:8]); end
        run_frame(24'h5A5A5A, 1'b1, 0);
        checks += 2;
        if (rx_data !== 24'h5A5A5A)       begin errors++; $display("FAIL lb2_rx_data: got %h want 5a5a5a", rx_data); end
        if (rx_crc_ok !== 1'b1)           begin errors++; $display("FAIL lb2_crc_ok: got %b want 1", rx_crc_ok); end
    endtask

    // Rise k=3 (cycle 15) carries frame bit 28, i.e. payload bit 20.
    task automatic test_crc_error();
        run_frame(24'hFEDCBA, 1'b1, 15);
        checks += 3;
        if (rx_data !== 24'hEEDCBA) begin errors++; $display("FAIL err_rx_data: got %h want eedcba", rx_data); end
        if (rx_crc_ok !== 1'b0)     begin errors++; $display("FAIL err_crc_ok: got %b want 0", rx_crc_ok); end
        if (o_done_cnt !== 1)       begin errors++; $display("FAIL err_done_count: got %0d want 1", o_done_cnt); end
    endtask

    task automatic test_reset_mid();
        int   n, falls, dones, busy_seen;
        logic prev_sck;
        @(negedge clk);
        tx_data = 24'h123456; loopback = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; falls = 0; prev_sck = 1'b0;
        while (falls < 10 && n < 200) begin
            if (!sck && prev_sck) falls++;
            prev_sck = sck;
            if (falls < 10) begin @(posedge clk); #1; n++; end
        end
        checks++;
        if (n !== 41) begin errors++; $display("FAIL rm_fall10_cycle: got %0d want 41", n); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 6;
        if (csn !== 1'b1)       begin errors++; $display("FAIL rm_csn: got %b want 1", csn); end
        if (sck !== 1'b0)       begin errors++; $display("FAIL rm_sck: got %b want 0", sck); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL rm_done: got %b want 0", done); end
        if (rx_data !== 24'h0)  begin errors++; $display("FAIL rm_rx_data: got %h want 000000", rx_data); end
        if (rx_crc_ok !== 1'b0) begin errors++; $display("FAIL rm_crc_ok: got %b want 0", rx_crc_ok); end
        dones = 0; busy_seen = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) busy_seen++;
        end
        checks += 2;
        if (dones !== 0)     begin errors++; $display("FAIL rm_no_done: got %0d want 0", dones); end
        if (busy_seen !== 0) begin errors++; $display("FAIL rm_stays_idle: got %0d want 0", busy_seen); end
        run_frame(24'h123456, 1'b1, 0);
        checks += 3;
        if (rx_data !== 24'h123456) begin errors++; $display("FAIL rm_after_rx: got %h want 123456", rx_data); end
        if (rx_crc_ok !== 1'b1)     begin errors++; $display("FAIL rm_after_ok: got %b want 1", rx_crc_ok); end
        if (o_busy_low !== 133)     begin errors++; $display("FAIL rm_after_len: got %0d want 133", o_busy_low); end
    endtask

    task automatic test_start_while_busy();
        int n, dones, busy_low, busy_after;
        @(negedge clk);
        tx_data = 24'h0F0F0F; loopback = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; busy_low = -1; busy_after = 0;
        for (n = 1; n <= 200; n++) begin
            if (done) dones++;
            if (!busy && busy_low < 0) busy_low = n;
            if (busy && busy_low >= 0) busy_after++;
            start = (n == 20 || n == 60 || n == 130 || n == 132);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks += 4;
        if (dones !== 1)            begin errors++; $display("FAIL swb_done_count: got %0d want 1", dones); end
        if (busy_low !== 133)       begin errors++; $display("FAIL swb_busy_low: got %0d want 133", busy_low); end
        if (busy_after !== 0)       begin errors++; $display("FAIL swb_no_queue: got %0d want 0", busy_after); end
        if (rx_data !== 24'h0F0F0F) begin errors++; $display("FAIL swb_rx_data: got %h want 0f0f0f", rx_data); end
    endtask

    task automatic test_back_to_back();
        int          n, nfall, ndone;
        int          fall_cyc[2], done_cyc[2];
        logic [23:0] done_rx[2];
        logic        prev_csn;
        @(negedge clk);
        tx_data = 24'hAAAAAA; loopback = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        tx_data = 24'h555555;
        nfall = 0; ndone = 0; prev_csn = 1'b1;
        fall_cyc = '{-1, -1}; done_cyc = '{-1, -1}; done_rx = '{24'h0, 24'h0};
        for (n = 1; n <= 300; n++) begin
            if (!csn && prev_csn) begin
                if (nfall < 2) fall_cyc[nfall] = n;
                nfall++;
            end
            if (done) begin
                if (ndone < 2) begin done_cyc[ndone] = n; done_rx[ndone] = rx_data; end
                ndone++;
            end
            prev_csn = csn;
            if (n == 264) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks += 9;
        if (nfall !== 2)               begin errors++; $display("FAIL b2b_frames: got %0d want 2", nfall); end
        if (fall_cyc[0] !== 1)         begin errors++; $display("FAIL b2b_fall0: got %0d want 1", fall_cyc[0]); end
        if (fall_cyc[1] !== 134)       begin errors++; $display("FAIL b2b_fall1: got %0d want 134", fall_cyc[1]); end
        if (ndone !== 2)               begin errors++; $display("FAIL b2b_dones: got %0d want 2", ndone); end
        if (done_cyc[0] !== 131)       begin errors++; $display("FAIL b2b_done0: got %0d want 131", done_cyc[0]); end
        if (done_cyc[1] !== 264)       begin errors++; $display("FAIL b2b_done1: got %0d want 264", done_cyc[1]); end
        if (done_rx[0] !== 24'hAAAAAA) begin errors++; $display("FAIL b2b_rx0: got %h want aaaaaa", done_rx[0]); end
        if (done_rx[1] !== 24'h555555) begin errors++; $display("FAIL b2b_rx1: got %h want 555555", done_rx[1]); end
        if (busy !== 1'b0)             begin errors++; $display("FAIL b2b_idle_end: got %b want 0", busy); end
    endtask

    task automatic test_div1();
        int   n, first_rise, done_at, busy_low;
        logic prev_sck, csn_c1;
        @(negedge clk);
        tx_data1 = 24'hA5C3E1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; tx_data1 = 24'h000000;
        first_rise = -1; done_at = -1; busy_low = -1; prev_sck = 1'b0; csn_c1 = 1'b1;
        for (n = 1; n <= 100 && busy_low < 0; n++) begin
            if (n == 1) csn_c1 = csn1;
            if (sck1 && !prev_sck && first_rise < 0) first_rise = n;
            if (done1) done_at = n;
            if (!busy1) busy_low = n;
            prev_sck = sck1;
            if (busy_low < 0) begin @(posedge clk); #1; end
        end
        checks += 6;
        if (csn_c1 !== 1'b0)         begin errors++; $display("FAIL d1_csn_c1: got %b want 0", csn_c1); end
        if (first_rise !== 2)        begin errors++; $display("FAIL d1_first_rise: got %0d want 2", first_rise); end
        if (done_at !== 66)          begin errors++; $display("FAIL d1_done: got %0d want 66", done_at); end
        if (busy_low !== 67)         begin errors++; $display("FAIL d1_busy_low: got %0d want 67", busy_low); end
        if (rx_data1 !== 24'hA5C3E1) begin errors++; $display("FAIL d1_rx_data: got %h want a5c3e1", rx_data1); end
        if (rx_crc_ok1 !== 1'b1)     begin errors++; $display("FAIL d1_crc_ok: got %b want 1", rx_crc_ok1); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_frame_contents();
        test_loopback();
        test_crc_error();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
